// File: rtl/gamepad_cmd_encoder.sv
// Polls a serial gamepad, debounces two consecutive identical frames and drives
// active-low direction/speed commands to a motor controller.
module gamepad_cmd_encoder #(
  parameter int CLK_DIV     = 300,
  parameter int POLL_CYCLES = 833333
) (
  input  logic clock,
  input  logic reset,
  input  logic pad_data,
  output logic pad_latch,
  output logic pad_clk,
  output logic bit0,
  output logic bit1,
  output logic bit2,
  output logic bit3,
  output logic bit4,
  output logic cmd_valid,
  output logic pad_fault
);

  localparam int TW = $clog2(POLL_CYCLES);
  localparam int DW = $clog2(2 * CLK_DIV);

  typedef enum logic [2:0] {IDLE, LATCH, CLK_LOW, CLK_HIGH, DONE} state_t;

  state_t          r_state, w_state_next;
  logic [TW-1:0]   r_timer;
  logic [DW-1:0]   r_div;
  logic [4:0]      r_pulse;
  logic [1:0]      r_sync;
  logic [15:0]     r_frame;
  logic [15:0]     r_prev;
  logic [4:0]      r_cmd;
  logic            r_cmd_valid;
  logic            r_fault;
  logic            w_phase_end;
  logic            w_frame_ok;

  // Direction priority Up > Down > Left > Right; inputs are active-low.
  function automatic logic [2:0] dir_code(input logic [15:0] f);
    if (!f[4])      return 3'b001;
    else if (!f[5]) return 3'b010;
    else if (!f[6]) return 3'b011;
    else if (!f[7]) return 3'b100;
    else            return 3'b000;
  endfunction

  always_comb begin
    w_phase_end = 1'b0;
    case (r_state)
      LATCH:            w_phase_end = (r_div == DW'(2 * CLK_DIV - 1));
      CLK_LOW, CLK_HIGH: w_phase_end = (r_div == DW'(CLK_DIV - 1));
      default:          w_phase_end = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (r_timer == TW'(POLL_CYCLES - 1)) w_state_next = LATCH;
      LATCH:    if (w_phase_end) w_state_next = CLK_LOW;
      CLK_LOW:  if (w_phase_end) w_state_next = CLK_HIGH;
      CLK_HIGH: if (w_phase_end) w_state_next = (r_pulse == 5'd16) ? DONE : CLK_LOW;
      DONE:     w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  assign w_frame_ok = &r_frame[15:12];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_div   <= '0;
      r_pulse <= '0;
      r_sync  <= 2'b11;
      r_frame <= 16'hFFFF;
    end else begin
      r_state <= w_state_next;
      r_sync  <= {r_sync[0], pad_data};
      r_timer <= (r_timer == TW'(POLL_CYCLES - 1)) ? '0 : r_timer + 1'b1;
      if (w_state_next != r_state) r_div <= '0;
      else if (r_state != IDLE)    r_div <= r_div + 1'b1;
      // Bit 0 is presented by the latch; bit n appears after rising edge n.
      if (r_state == LATCH && w_phase_end) begin
        r_frame[0] <= r_sync[1];
        r_pulse    <= 5'd1;
      end else if (r_state == CLK_HIGH && w_phase_end) begin
        if (r_pulse != 5'd16) r_frame[r_pulse[3:0]] <= r_sync[1];
        r_pulse <= r_pulse + 1'b1;
      end
    end
  end

  // Debounce and command update, all decided in DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev      <= 16'hFFFF;
      r_cmd       <= 5'b11111;
      r_cmd_valid <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      if (r_state == DONE) begin
        r_prev <= r_frame;
        if (!w_frame_ok) begin
          r_cmd       <= 5'b11111;
          r_fault     <= 1'b1;
          r_cmd_valid <= 1'b1;
        end else begin
          r_fault <= 1'b0;
          if (r_frame == r_prev) begin
            r_cmd       <= {r_frame[11], r_frame[10], ~dir_code(r_frame)};
            r_cmd_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign pad_latch = (r_state == LATCH);
  assign pad_clk   = (r_state != CLK_LOW);
  assign {bit4, bit3, bit2, bit1, bit0} = r_cmd;
  assign cmd_valid = r_cmd_valid;
  assign pad_fault = r_fault;

endmodule

// File: tb/tb_gamepad_cmd_encoder.sv
// Directed bench: a behavioural shift-register pad feeds hand-picked frames and
// the command outputs are compared against hand-computed codes.
module tb_gamepad_cmd_encoder;

  localparam int CD = 4;
  localparam int PC = 200;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pad_data;
  logic pad_latch, pad_clk;
  logic bit0, bit1, bit2, bit3, bit4;
  logic cmd_valid, pad_fault;

  logic [15:0] pad_frame = 16'hFFFF;
  logic [15:0] pad_sreg  = 16'hFFFF;
  logic        pclk_d    = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  gamepad_cmd_encoder #(.CLK_DIV(CD), .POLL_CYCLES(PC)) dut (
    .clock(clock), .reset(reset), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk),
    .bit0(bit0), .bit1(bit1), .bit2(bit2), .bit3(bit3), .bit4(bit4),
    .cmd_valid(cmd_valid), .pad_fault(pad_fault)
  );

  always #5 clock = ~clock;

  // Pad model: parallel load while latched, shift on each pad_clk rising edge.
  always @(posedge clock) begin
    pclk_d <= pad_clk;
    if (pad_latch)             pad_sreg <= pad_frame;
    else if (pad_clk && !pclk_d) pad_sreg <= {1'b1, pad_sreg[15:1]};
  end
  assign pad_data = pad_sreg[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bit4, bit3, bit2, bit1, bit0};
  endfunction

  // One full poll frame: wait for the latch, then watch past DONE.
  task automatic run_frame(input string tag, input logic [15:0] f,
                           input logic [4:0] exp_bits, input int exp_pulses,
                           input logic exp_fault);
    int n;
    int pulses;
    pad_frame = f;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!pad_latch && n < 260);
    chk({tag, "_latch_seen"}, 32'(pad_latch), 32'd1);
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if (cmd_valid) pulses++;
    end
    chk({tag, "_bits"}, 32'(outs()), 32'(exp_bits));
    chk({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    chk({tag, "_fault"}, 32'(pad_fault), 32'(exp_fault));
  endtask

  localparam logic [15:0] F_NONE   = 16'hFFFF;
  localparam logic [15:0] F_UP     = 16'hFFEF;
  localparam logic [15:0] F_UPLEFT = 16'hFFAF;
  localparam logic [15:0] F_LEFT   = 16'hFFBF;
  localparam logic [15:0] F_RIGHT  = 16'hFF7F;
  localparam logic [15:0] F_LR     = 16'hF3FF;
  localparam logic [15:0] F_BADID  = 16'hDFEF;

  initial begin
    int n;
    int lows;
    int rises;
    int pulses;
    logic prev_clk;

    repeat (3) @(negedge clock);
    chk("rst_latch", 32'(pad_latch), 32'd0);
    chk("rst_padclk", 32'(pad_clk), 32'd1);
    chk("rst_bits", 32'(outs()), 32'h1F);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_fault", 32'(pad_fault), 32'd0);

    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!pad_latch && n < 400);
    chk("first_latch_cycle", 32'(n), 32'd200);
    n = 1;
    @(negedge clock);
    while (pad_latch && n < 50) begin
      n++;
      @(negedge clock);
    end
    chk("latch_width", 32'(n), 32'(2 * CD));
    lows = 0; rises = 0; pulses = 0; prev_clk = 1'b1;
    for (int i = 0; i < 32 * CD + 4; i++) begin
      if (!pad_clk) lows++;
      if (pad_clk && !prev_clk) rises++;
      if (cmd_valid) pulses++;
      prev_clk = pad_clk;
      @(negedge clock);
    end
    chk("clk_low_cycles", 32'(lows), 32'(16 * CD));
    chk("clk_pulses", 32'(rises), 32'd16);
    chk("idle_bits", 32'(outs()), 32'h1F);
    chk("idle_frame_valid", 32'(pulses), 32'd1);

    run_frame("up1", F_UP, 5'b11111, 0, 1'b0);
    run_frame("up2", F_UP, 5'b11110, 1, 1'b0);
    run_frame("upleft1", F_UPLEFT, 5'b11110, 0, 1'b0);
    run_frame("upleft2", F_UPLEFT, 5'b11110, 1, 1'b0);
    run_frame("left1", F_LEFT, 5'b11110, 0, 1'b0);
    run_frame("left2", F_LEFT, 5'b11100, 1, 1'b0);
    run_frame("right1", F_RIGHT, 5'b11100, 0, 1'b0);
    run_frame("right2", F_RIGHT, 5'b11011, 1, 1'b0);
    run_frame("lr1", F_LR, 5'b11011, 0, 1'b0);
    run_frame("lr2", F_LR, 5'b00111, 1, 1'b0);
    run_frame("rel1", F_NONE, 5'b00111, 0, 1'b0);
    run_frame("rel2", F_NONE, 5'b11111, 1, 1'b0);
    run_frame("fwd1", F_UP, 5'b11111, 0, 1'b0);
    run_frame("fwd2", F_UP, 5'b11110, 1, 1'b0);
    run_frame("badid", F_BADID, 5'b11111, 1, 1'b1);
    run_frame("recov1", F_UP, 5'b11111, 0, 1'b0);
    run_frame("recov2", F_UP, 5'b11110, 1, 1'b0);

    // Abort a frame mid-shift with reset.
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (pad_clk && n < 300);
    chk("found_clk_low", 32'(pad_clk), 32'd0);
    reset = 1'b1;
    #1;
    chk("abort_padclk", 32'(pad_clk), 32'd1);
    chk("abort_latch", 32'(pad_latch), 32'd0);
    chk("abort_bits", 32'(outs()), 32'h1F);
    chk("abort_valid", 32'(cmd_valid), 32'd0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (cmd_valid) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 32'd0);
    reset = 1'b0;
    run_frame("post_rst1", F_UP, 5'b11111, 0, 1'b0);
    run_frame("post_rst2", F_UP, 5'b11110, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
